fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the processor decoder. Drives the address of the combinational program ROM and registers the returned 16-bit word into an output instruction register.
- Presents the word to decode with a valid/ready handshake and tracks the program counter.
- Supports start, redirect (jump/branch) and halt-on-HALT-word.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_pc_reg.sv | 28 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// State encoding, default widths and instruction field layout.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int INST_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Opcode field [15:12]
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam logic [3:0] OPC_ADDI = 4'b0001;
    localparam logic [3:0] OPC_OUT  = 4'b1111;

    // Destination register field [11:9]
    localparam int REG_HI = 11;
    localparam int REG_LO = 9;

    localparam logic [15:0] HALT_INST_DEF = 16'h0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with load / increment / hold.
// Ports: clk, rst, load, load_addr, inc -> pc. Load beats increment.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            // Wraps silently modulo 2**ADDR_W
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives ROM address, registers words for decode.
// Ports: clk/rst, start, rom_addr/rom_data, redirect_*, inst_* handshake, running/halted.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                INST_W    = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              running,
    output logic              halted
);

    fetch_state_e state, state_next;

    logic [ADDR_W-1:0] pc;
    logic take;
    logic slot_free;
    logic fetch;
    logic halt_hit;
    logic load_word;
    logic valid_next;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (redirect_valid),
        .load_addr (redirect_addr),
        .inc       (fetch),
        .pc        (pc)
    );

    assign rom_addr = pc;

    // State register; running/halted track the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
            halted  <= (state_next == ST_HALTED);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt_hit) state_next = ST_HALTED;
            end
            ST_HALTED: begin
                if (start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Fetch controls
    always_comb begin
        take      = inst_valid & inst_ready;
        slot_free = ~inst_valid | inst_ready;
        // Redirect owns the pc this cycle, so it suppresses the fetch
        fetch     = (state == ST_RUN) & slot_free & ~redirect_valid;
        halt_hit  = fetch & (rom_data == HALT_INST);
        load_word = fetch & ~halt_hit;
        if (redirect_valid) begin
            valid_next = 1'b0;
        end else if (load_word) begin
            valid_next = 1'b1;
        end else begin
            valid_next = take ? 1'b0 : inst_valid;
        end
    end

    // Output instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            inst_valid <= valid_next;
            if (load_word) begin
                inst    <= rom_data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Directed scenarios plus a randomized stream scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        redirect_valid;
    logic [3:0]  redirect_addr;
    logic        inst_valid;
    logic [15:0] inst;
    logic [3:0]  inst_pc;
    logic        inst_ready;
    logic        running;
    logic        halted;

    logic [15:0] rom [16];
    int checks = 0;
    int failures = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .running        (running),
        .halted         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        rom[0] = 16'h1001;
        rom[1] = 16'hF000;
        for (int i = 2; i < 16; i++) rom[i] = 16'h1000 + 16'(i * 3 + 1);
    endtask

    task automatic do_reset();
        start = 0;
        redirect_valid = 0;
        redirect_addr = 0;
        inst_ready = 1;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        load_rom();
        do_reset();
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 4'd0 || running !== 1'b0 ||
            halted !== 1'b0 || inst !== 16'h0 || inst_pc !== 4'd0) begin
            failures++;
            $display("FAIL reset: valid=%b addr=%0d run=%b halt=%b inst=%h ipc=%0d want all 0",
                     inst_valid, rom_addr, running, halted, inst, inst_pc);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0 || running !== 1'b0 || rom_addr !== 4'd0) begin
            failures++;
            $display("FAIL idle_no_fetch: valid=%b run=%b addr=%0d want 0 0 0",
                     inst_valid, running, rom_addr);
        end
    endtask

    task automatic test_first_words();
        do_reset();
        start = 1;
        step();
        start = 0;
        checks++;
        if (running !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_latency: run=%b valid=%b want 1 0", running, inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 16'h1001 || inst_pc !== 4'd0) begin
            failures++;
            $display("FAIL first_word: valid=%b inst=%h ipc=%0d want 1 1001 0",
                     inst_valid, inst, inst_pc);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 16'hF000 || inst_pc !== 4'd1) begin
            failures++;
            $display("FAIL second_word: valid=%b inst=%h ipc=%0d want 1 f000 1",
                     inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        start = 1;
        step();
        start = 0;
        step();
        inst_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (inst !== 16'h1001 || inst_pc !== 4'd0 || rom_addr !== 4'd1 ||
                inst_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: inst=%h ipc=%0d addr=%0d valid=%b want 1001 0 1 1",
                         i, inst, inst_pc, rom_addr, inst_valid);
            end
        end
        inst_ready = 1;
        step();
        checks++;
        if (inst !== 16'hF000 || inst_pc !== 4'd1) begin
            failures++;
            $display("FAIL stall_release: inst=%h ipc=%0d want f000 1", inst, inst_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 4'(i) || inst !== rom[i % 16] ||
                running !== 1'b1) begin
                failures++;
                $display("FAIL wrap[%0d]: valid=%b ipc=%0d inst=%h run=%b want 1 %0d %h 1",
                         i, inst_valid, inst_pc, inst, running, i % 16, rom[i % 16]);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1;
        step();
        start = 0;
        step();
        inst_ready = 0;
        redirect_valid = 1;
        redirect_addr = 4'd9;
        step();
        redirect_valid = 0;
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 4'd9 || running !== 1'b1) begin
            failures++;
            $display("FAIL redirect_flush: valid=%b addr=%0d run=%b want 0 9 1",
                     inst_valid, rom_addr, running);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 4'd9 || inst !== rom[9]) begin
            failures++;
            $display("FAIL redirect_target: valid=%b ipc=%0d inst=%h want 1 9 %h",
                     inst_valid, inst_pc, inst, rom[9]);
        end
        inst_ready = 1;
    endtask

    task automatic test_start_redirect_idle();
        do_reset();
        start = 1;
        redirect_valid = 1;
        redirect_addr = 4'd5;
        step();
        start = 0;
        redirect_valid = 0;
        checks++;
        if (running !== 1'b1 || rom_addr !== 4'd5 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_redirect: run=%b addr=%0d valid=%b want 1 5 0",
                     running, rom_addr, inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 4'd5) begin
            failures++;
            $display("FAIL start_redirect_fetch: valid=%b ipc=%0d want 1 5", inst_valid, inst_pc);
        end
    endtask

    task automatic test_halt();
        load_rom();
        rom[3] = 16'h0000;
        do_reset();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 4'(i) || inst !== rom[i]) begin
                failures++;
                $display("FAIL halt_prefix[%0d]: valid=%b ipc=%0d inst=%h want 1 %0d %h",
                         i, inst_valid, inst_pc, inst, i, rom[i]);
            end
        end
        step();
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 4'd4) begin
            failures++;
            $display("FAIL halt_state: halt=%b run=%b valid=%b addr=%0d want 1 0 0 4",
                     halted, running, inst_valid, rom_addr);
        end
        step();
        step();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 4'd4) begin
            failures++;
            $display("FAIL halt_hold: halt=%b valid=%b addr=%0d want 1 0 4",
                     halted, inst_valid, rom_addr);
        end
        start = 1;
        step();
        start = 0;
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 4'd4 || inst !== rom[4] || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_resume: valid=%b ipc=%0d inst=%h halt=%b want 1 4 %h 0",
                     inst_valid, inst_pc, inst, halted, rom[4]);
        end
        load_rom();
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start = 1;
        step();
        start = 0;
        step();
        step();
        inst_ready = 0;
        rst = 1;
        step();
        rst = 0;
        inst_ready = 1;
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 4'd0 || running !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun: valid=%b addr=%0d run=%b halt=%b want 0 0 0 0",
                     inst_valid, rom_addr, running, halted);
        end
        step();
        step();
        checks++;
        if (inst_valid !== 1'b0 || rom_addr !== 4'd0) begin
            failures++;
            $display("FAIL reset_no_fetch: valid=%b addr=%0d want 0 0", inst_valid, rom_addr);
        end
    endtask

    // Taken words must follow program order from the last redirect
    // target, each word being rom[pc]; flushed words never appear.
    task automatic test_random_stream();
        int exp_pc;
        int delivered;
        logic tk;
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom_range(1, 65535));
        do_reset();
        start = 1;
        step();
        start = 0;
        exp_pc = 0;
        delivered = 0;
        for (int c = 0; c < 400; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_addr = 4'($urandom_range(0, 15));
            #1;
            tk = inst_valid & inst_ready;
            if (tk) begin
                checks++;
                delivered++;
                if (inst_pc !== 4'(exp_pc) || inst !== rom[exp_pc]) begin
                    failures++;
                    $display("FAIL stream[%0d]: ipc=%0d inst=%h want %0d %h",
                             c, inst_pc, inst, exp_pc, rom[exp_pc]);
                end
                exp_pc = (exp_pc + 1) % 16;
            end
            if (redirect_valid) exp_pc = int'(redirect_addr);
            step();
        end
        redirect_valid = 0;
        inst_ready = 1;
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL stream_progress: delivered=%0d want >=100", delivered);
        end
        load_rom();
    endtask

    initial begin
        rst = 1;
        start = 0;
        redirect_valid = 0;
        redirect_addr = 0;
        inst_ready = 1;
        load_rom();
        test_reset();
        test_first_words();
        test_stall();
        test_wrap();
        test_redirect();
        test_start_redirect_idle();
        test_halt();
        test_reset_midrun();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
